serial_add_ctrl: RTL and testbench
==================================

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: in_valid  input  1  operand set a, b, cin is presented.
REQ-005 Port: in_ready  output  1  block accepts operands this cycle.
REQ-006 Port: a  input  WIDTH  addend A, unsigned.
REQ-007 Port: b  input  WIDTH  addend B, unsigned.
REQ-008 Port: cin  input  1  carry-in for the LSB.
REQ-009 Port: out_valid  output  1  sum and cout hold a completed result.
REQ-010 Port: out_ready  input  1  consumer takes the result this cycle.
REQ-011 Port: sum  output  WIDTH  result bits, a + b + cin modulo 2^WIDTH.
REQ-012 Port: cout  output  1  final carry-out of the MSB.
REQ-013 Port: busy  output  1  high while a bit-serial addition is in progress.

Function
REQ-014 The block SHALL compute sum/cout bit-serially, one bit per clock, LSB first, using a single full-adder instance.
REQ-015 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-016 IDLE: in_ready=1, busy=0, out_valid=0; on an edge with in_valid=1, capture a and b into shift registers, load the carry register from cin, clear the bit counter, and go to RUN.
REQ-017 RUN: on each edge, feed shifted bit 0 of A and B plus the carry register to the adder; shift the sum bit into the result register MSB (right shift); load the carry register from adder cout; increment the counter.
REQ-018 RUN SHALL last exactly WIDTH edges; on the edge where the counter equals WIDTH-1, go to DONE.
REQ-019 Latency: out_valid SHALL rise exactly WIDTH rising edges after the accepting edge.
REQ-020 DONE: out_valid=1; sum = result register; cout = carry register; both stable until the handshake.
REQ-021 DONE and out_ready=1: go to IDLE on that edge; out_valid falls the following cycle.
REQ-022 DONE and out_ready=0: hold indefinitely (backpressure); the result SHALL NOT change.
REQ-023 in_ready SHALL be 0 in RUN and DONE; in_valid is ignored there and operands are not sampled.
REQ-024 Simultaneous out_ready (DONE) and in_valid: no operand is accepted that cycle; new operands are accepted no earlier than the first IDLE cycle. Minimum issue interval is WIDTH+2 cycles.
REQ-025 busy SHALL equal (state == RUN).
REQ-026 sum and cout SHALL read 0 in IDLE and RUN; intermediate bits are not exposed.
REQ-027 The counter SHALL be clog2(WIDTH) bits and SHALL never wrap within one operation.

Reset
REQ-028 Asserting rst SHALL asynchronously force IDLE and clear all registers: in_ready=1 and out_valid=0, busy=0, sum=0, cout=0.
REQ-029 Reset during RUN or DONE SHALL abort the operation with no output handshake; the first post-reset operation SHALL be unaffected.

Structure
REQ-030 The shared package SHALL hold the FSM state encoding (IDLE=2'b00, RUN=2'b01, DONE=2'b10) and the default WIDTH constant.
REQ-031 The existing full_adder module SHALL be instantiated exactly once as the only sub-module; no '+' operator on the data path.

Verification (WIDTH=8)
REQ-032 Stimulus a=0x5A, b=0x3C, cin=0 -> sum=0x96, cout=0, with out_valid 8 edges after accept.
REQ-033 Stimulus a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; then a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1.
REQ-034 Hold out_ready=0 for 5 cycles in DONE -> out_valid, sum, and cout stable; in_ready=0 throughout; release -> IDLE next edge.
REQ-035 Hold in_valid=1 continuously with new operands each issue -> accepts are spaced exactly 10 cycles apart; no operand is sampled during RUN or DONE.
REQ-036 Assert rst at RUN bit 4 of a 0xAA+0x55 add -> all outputs are at reset values immediately; the next add 0x01+0x01 cin=0 gives sum=0x02, cout=0.

Source files
------------

// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: state encoding,
// default operand width and the counter sizing helper.
package serial_add_ctrl_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Bit counter width; never below one bit so WIDTH=2 still gets a counter.
  function automatic int cnt_bits(input int width);
    return (width < 3) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Operand/result handshake bundle for serial_add_ctrl.
// The master drives operands and takes results; the slave is the adder.
interface serial_add_ctrl_if
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );

endinterface

// File: rtl/serial_add_ctrl_full_adder.sv
// One-bit full adder; the only arithmetic element of the serial data path.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  // Sum and carry from pure gate logic.
  always_comb begin
    s  = a ^ b ^ ci;
    co = (a & b) | (ci & (a ^ b));
  end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: accepts a, b, cin, adds one bit per clock
// LSB first through a single full adder, then holds the result until taken.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | ready for operands, outputs read zero
//   RUN     | shifting operands through the full adder, WIDTH edges
//   DONE    | result valid and frozen until the consumer takes it
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  serial_add_ctrl_if.slave  bus
);

  localparam int             CW       = cnt_bits(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  state_t            state;
  logic [WIDTH-1:0]  a_sr;
  logic [WIDTH-1:0]  b_sr;
  logic [WIDTH-1:0]  res_sr;
  logic              carry;
  logic [CW-1:0]     cnt;
  logic              in_ready_q;
  logic              busy_q;
  logic              out_valid_q;
  logic              fa_s;
  logic              fa_co;

  full_adder u_fa (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  // Control FSM and serial data path; flags are registered with the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      a_sr        <= '0;
      b_sr        <= '0;
      res_sr      <= '0;
      carry       <= 1'b0;
      cnt         <= '0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            a_sr       <= bus.a;
            b_sr       <= bus.b;
            carry      <= bus.cin;
            res_sr     <= '0;
            cnt        <= '0;
            state      <= ST_RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        ST_RUN: begin
          a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
          res_sr <= {fa_s, res_sr[WIDTH-1:1]};
          carry  <= fa_co;
          // Hold the counter on the last bit so it never wraps.
          if (cnt == CNT_LAST) begin
            state       <= ST_DONE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            state       <= ST_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            res_sr      <= '0;
            carry       <= 1'b0;
          end
        end
        default: begin
          state       <= ST_IDLE;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Result is only exposed while valid; partial bits stay hidden.
  always_comb begin
    bus.in_ready  = in_ready_q;
    bus.busy      = busy_q;
    bus.out_valid = out_valid_q;
    bus.sum       = out_valid_q ? res_sr : '0;
    bus.cout      = out_valid_q & carry;
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl at WIDTH=8.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  serial_add_ctrl_if #(.WIDTH(W)) bus ();

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    int           acc;
  } exp_t;

  exp_t sb[$];
  int   last_acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                       input logic [W-1:0] es, input logic ec, input bit keep);
    int n;
    bit got;
    n   = 0;
    got = 0;
    bus.in_valid = 1'b1;
    bus.a        = av;
    bus.b        = bv;
    bus.cin      = cv;
    while (!got && n < 60) begin
      if (bus.in_ready === 1'b1) got = 1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    if (!got) begin
      fail_now("accept_timeout");
      bus.in_valid = 1'b0;
      return;
    end
    last_acc = cyc + 1;
    sb.push_back('{es, ec, cyc + 1});
    @(posedge clk);
    @(negedge clk);
    if (!keep) bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) fail_now("idle_timeout");
    @(negedge clk);
  endtask

  // Monitor: invariants every cycle, latency on result rise, data on handshake.
  logic prev_v = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_v <= 1'b0;
    end else begin
      chk("busy_vs_flags", {31'b0, bus.busy}, {31'b0, (!bus.in_ready && !bus.out_valid)});
      if (!bus.out_valid) chk("outputs_zero_when_invalid", {23'b0, bus.cout, bus.sum}, 32'h0);
      if (bus.out_valid && !prev_v) begin
        if (sb.size() == 0) fail_now("unexpected_out_valid");
        else chk("latency", cyc - sb[0].acc, W);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) fail_now("unexpected_result");
        else begin
          e = sb.pop_front();
          chk("sum", {24'b0, bus.sum}, {24'b0, e.s});
          chk("cout", {31'b0, bus.cout}, {31'b0, e.c});
        end
      end
      prev_v <= bus.out_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] hs;
    logic         hc;
    int           acc_t[4];

    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {31'b0, bus.in_ready}, 32'h1);
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'h0);
    chk("rst_busy", {31'b0, bus.busy}, 32'h0);
    chk("rst_sum", {24'b0, bus.sum}, 32'h0);
    chk("rst_cout", {31'b0, bus.cout}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Basic adds and carry-out cases.
    issue(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 0);
    wait_idle();
    issue(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0);
    wait_idle();
    issue(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 0);
    wait_idle();

    // Backpressure: result must freeze in DONE.
    bus.out_ready = 1'b0;
    issue(8'hC3, 8'h5A, 1'b0, 8'h1D, 1'b1, 0);
    begin
      int n;
      n = 0;
      while (bus.out_valid !== 1'b1 && n < 60) begin
        @(negedge clk);
        n++;
      end
      if (n >= 60) fail_now("done_timeout");
    end
    hs = bus.sum;
    hc = bus.cout;
    chk("hold_first_sum", {24'b0, hs}, 32'h1D);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_out_valid", {31'b0, bus.out_valid}, 32'h1);
      chk("hold_sum", {24'b0, bus.sum}, {24'b0, hs});
      chk("hold_cout", {31'b0, bus.cout}, {31'b0, hc});
      chk("hold_in_ready", {31'b0, bus.in_ready}, 32'h0);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("release_out_valid", {31'b0, bus.out_valid}, 32'h0);
    chk("release_in_ready", {31'b0, bus.in_ready}, 32'h1);
    @(negedge clk);

    // Back-to-back issue with in_valid held high throughout.
    issue(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1);
    acc_t[0] = last_acc;
    issue(8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1);
    acc_t[1] = last_acc;
    issue(8'hF0, 8'h0F, 1'b1, 8'h00, 1'b1, 1);
    acc_t[2] = last_acc;
    issue(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 0);
    acc_t[3] = last_acc;
    for (int i = 1; i < 4; i++) chk("issue_spacing", acc_t[i] - acc_t[i-1], W + 2);
    wait_idle();

    // Reset in the middle of RUN aborts the add without a result.
    issue(8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 0);
    repeat (4) @(posedge clk);
    #2;
    chk("busy_in_run", {31'b0, bus.busy}, 32'h1);
    rst = 1'b1;
    #1;
    chk("arst_in_ready", {31'b0, bus.in_ready}, 32'h1);
    chk("arst_out_valid", {31'b0, bus.out_valid}, 32'h0);
    chk("arst_busy", {31'b0, bus.busy}, 32'h0);
    chk("arst_sum", {24'b0, bus.sum}, 32'h0);
    chk("arst_cout", {31'b0, bus.cout}, 32'h0);
    sb.delete();
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    issue(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 0);
    wait_idle();

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
